avr_fetch: RTL and testbench
============================

# avr_fetch

Instruction-fetch stage between the 1K×16 program-flash ROM and the AVR decoder. It drives the ROM read port and tracks the one-cycle ROM read latency. Fetched words go into a 3-entry prefetch buffer, which presents complete one- or two-word instructions to the decoder over a valid/ready handshake. Branch/jump redirects flush the buffer and restart fetch at the new PC.

## Interface
Parameters: none. Widths come from the shared package: `ROM_AW` = 10, `RESET_PC` = 10'h000.

Ports:
- `clk`  in  1  — single clock; everything is clocked on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `mem_ce`  out  1  — ROM read enable.
- `mem_a`  out  10  — ROM word address.
- `mem_d`  in  16  — ROM read data. It is valid the cycle after `mem_a`/`mem_ce=1` are presented.
- `jmp_valid`  in  1  — one-cycle redirect request.
- `jmp_pc`  in  10  — redirect target word address.
- `ins_valid`  out  1  — a complete instruction is presented.
- `ins_ready`  in  1  — decoder accepts.
- `ins_pc`  out  10  — word address of `ins_word0`.
- `ins_word0`  out  16  — first instruction word.
- `ins_word1`  out  16  — second word. It is 16'h0000 when `ins_len`=0.
- `ins_len`  out  1  — 0 for a one-word instruction, 1 for a two-word instruction.

## Operation
- **State**
  - `fpc`: next fetch address.
  - `inflight`: a read issued last cycle, so data arrives this cycle.
  - Buffer of up to 3 entries of {word, pc}; `count` is 0..3.
- **Issue**
  - Condition: `!rst && (jmp_valid || count + inflight < 3)`.
  - On issue, `mem_ce`=1.
  - `mem_a` = `jmp_valid ? jmp_pc : fpc`. This is combinational.
  - After the issue, `fpc` ← `mem_a + 1` (mod 1024).
  - When no read is issued, `mem_ce`=0 and `mem_a`=`fpc`. The address is held stable, so the ROM bank-select register sees no spurious change.
- **Capture**
  - If `inflight` and `!jmp_valid`, push {`mem_d`, pc of that read} at the tail.
  - The pc travels with `inflight` in a 10-bit register.
- **Two-word detection** on the head word:
  - `(w & 16'hFC0F) == 16'h9000` (LDS/STS), or
  - `(w & 16'hFE0C) == 16'h940C` (JMP/CALL).
- **Present**
  - `ins_valid` = `count ≥ 1 && (!two_word(head) || count ≥ 2)`.
  - `ins_word0` is entry 0; `ins_word1` is entry 1 when `ins_len`=1.
- **Transfer** when `ins_valid && ins_ready`: pop 1 + `ins_len` entries. A pop and a push in the same cycle are allowed; the buffer shifts and appends.
- **Redirect** on `jmp_valid`:
  - Buffer cleared (`count` ← 0); the arriving in-flight word is discarded.
  - A new read at `jmp_pc` is issued in the same cycle.
  - A transfer in the redirect cycle still completes. A redirect takes priority over push.
- **Wrap**: addresses wrap from 0x3FF to 0x000. A two-word instruction at 0x3FF takes its `ins_word1` from 0x000.
- **Reset**:
  - `fpc`←0, `inflight`←0, `count`←0.
  - While `rst`=1: `mem_ce`=0, `mem_a`=0, `ins_valid`=0, `ins_word0/1`=0, `ins_pc`=0, `ins_len`=0.
  - Reset mid-operation drops all buffered and in-flight words.

## Timing
- After `rst` falls (cycle 0): read of 0x000 in cycle 0; the word is captured at end of cycle 1; `ins_valid`=1 in cycle 2.
- Redirect in cycle C: `mem_a`=`jmp_pc` in C; `ins_valid`=0 in C+1; first target instruction valid in C+2.
- Steady state with `ins_ready`=1 and one-word instructions: one instruction per cycle with consecutive `ins_pc`.
- Backpressure: reads stop once `count + inflight` = 3. No word is lost or duplicated.
- `ins_*` outputs are registered-state derived, with no combinational path from `ins_ready`. `mem_ce`/`mem_a` do depend combinationally on `jmp_valid`/`jmp_pc`.

## Structure
- **Package `avr_pkg`** holds:
  - `ROM_AW` and `RESET_PC`;
  - the LDS/STS and JMP/CALL masks and match values;
  - function `is_two_word(w)`;
  - the typedef for a buffer entry {word, pc}.
- **Sub-module `fetch_buf`**: 3-entry shift FIFO.
  - Push 1, pop 0/1/2, synchronous clear.
  - Outputs `count` and entries 0 and 1.

## Test plan
Bench ROM model has one-cycle latency and registered bank select.
1. Reset release with ROM[0..3] = C004, C03A, C001, C023 and `ins_ready`=1 → `ins_valid` first in cycle 2 at pc 0 with word0 C004; then pc 1, 2, 3 on consecutive cycles, `ins_len`=0.
2. ROM[5]=940C, ROM[6]=0034 → one transfer with pc 5, word0 940C, word1 0034, `ins_len`=1; next `ins_pc`=7.
3. `ins_ready`=0 for 10 cycles → `mem_ce` drops after `count`=3 and `ins_pc` stays fixed; on release, pcs continue consecutively with no gap or repeat.
4. `jmp_valid` with `jmp_pc`=0x123 while the buffer is full → `mem_a`=0x123 in the same cycle, `ins_valid`=0 next cycle, `ins_pc`=0x123 two cycles later; no pre-jump word appears.
5. Jump to 0x3FF with ROM[3FF]=9100 and ROM[000]=0060 → word1 0060, `ins_len`=1; next `ins_pc`=0x001.
6. `rst` for 1 cycle while the buffer is full and a read is in flight → `ins_valid`=0 and `mem_ce`=0 during reset; fetch restarts at 0x000 with `ins_valid` 2 cycles after release.

Source files
------------

// File: rtl/avr_pkg.sv
// avr_pkg: shared types and constants for the AVR front end.
// Holds ROM geometry, two-word opcode masks and the fetch-buffer entry.
package avr_pkg;

  localparam int ROM_AW = 10;
  localparam logic [ROM_AW-1:0] RESET_PC = '0;

  localparam logic [15:0] LDS_MASK  = 16'hFC0F;
  localparam logic [15:0] LDS_MATCH = 16'h9000;
  localparam logic [15:0] JMP_MASK  = 16'hFE0C;
  localparam logic [15:0] JMP_MATCH = 16'h940C;

  typedef struct packed {
    logic [15:0]       word;
    logic [ROM_AW-1:0] pc;
  } buf_ent_t;

  function automatic logic is_two_word(
    input logic [15:0] w
  );
    return ((w & LDS_MASK) == LDS_MATCH) ||
           ((w & JMP_MASK) == JMP_MATCH);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 3-entry shift FIFO of {word, pc}.
// Push one, pop zero/one/two per cycle, with synchronous clear.
module fetch_buf
  import avr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  buf_ent_t   push_ent,
  input  logic [1:0] pop,
  output logic [1:0] count,
  output buf_ent_t   ent0,
  output buf_ent_t   ent1
);

  buf_ent_t   q   [3];
  buf_ent_t   q_n [3];
  logic [1:0] left;
  logic [1:0] cnt_n;

  // shift out popped entries, then append at the new tail
  always_comb begin
    q_n   = q;
    left  = count;
    cnt_n = count;
    unique case (pop)
      2'd1: begin
        q_n[0] = q[1];
        q_n[1] = q[2];
        q_n[2] = '0;
        left   = count - 2'd1;
      end
      2'd2: begin
        q_n[0] = q[2];
        q_n[1] = '0;
        q_n[2] = '0;
        left   = count - 2'd2;
      end
      default: ;
    endcase
    cnt_n = left;
    if (push && left != 2'd3) begin
      unique case (left)
        2'd0:    q_n[0] = push_ent;
        2'd1:    q_n[1] = push_ent;
        2'd2:    q_n[2] = push_ent;
        default: ;
      endcase
      cnt_n = left + 2'd1;
    end
    if (clr) begin
      cnt_n = '0;
    end
  end

  // entry storage and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      q     <= '{default: '0};
    end else begin
      count <= cnt_n;
      q     <= q_n;
    end
  end

  assign ent0 = q[0];
  assign ent1 = q[1];

endmodule

// File: rtl/avr_fetch.sv
// avr_fetch: ROM read issue, latency tracking and instruction
// assembly from a 3-entry prefetch buffer with jump redirect.
module avr_fetch
  import avr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mem_ce,
  output logic [ROM_AW-1:0] mem_a,
  input  logic [15:0]       mem_d,
  input  logic              jmp_valid,
  input  logic [ROM_AW-1:0] jmp_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [ROM_AW-1:0] ins_pc,
  output logic [15:0]       ins_word0,
  output logic [15:0]       ins_word1,
  output logic              ins_len
);

  logic [ROM_AW-1:0] fpc;
  logic [ROM_AW-1:0] infl_pc;
  logic              inflight;
  logic [1:0]        count;
  buf_ent_t          ent0;
  buf_ent_t          ent1;
  buf_ent_t          push_ent;
  logic [2:0]        occ;
  logic              issue;
  logic              push;
  logic              two_w;
  logic              xfer;
  logic [1:0]        pop;

  // read issue; address holds at fpc when idle
  always_comb begin
    occ    = {1'b0, count} + {2'b00, inflight};
    issue  = !rst && (jmp_valid || occ < 3'd3);
    mem_ce = issue;
    mem_a  = fpc;
    if (rst) begin
      mem_a = '0;
    end else if (jmp_valid) begin
      mem_a = jmp_pc;
    end
  end

  // decoder-facing instruction from buffer head
  always_comb begin
    two_w     = is_two_word(ent0.word);
    ins_len   = !rst && count != 2'd0 && two_w;
    ins_valid = !rst && count != 2'd0 &&
                (!two_w || count >= 2'd2);
    ins_pc    = rst ? '0 : ent0.pc;
    ins_word0 = rst ? '0 : ent0.word;
    ins_word1 = ins_len ? ent1.word : '0;
    xfer      = ins_valid && ins_ready;
    pop       = xfer ? (ins_len ? 2'd2 : 2'd1) : 2'd0;
    push      = inflight && !jmp_valid;
    push_ent  = '{word: mem_d, pc: infl_pc};
  end

  // fetch pointer and in-flight read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      inflight <= 1'b0;
      infl_pc  <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc     <= mem_a + ROM_AW'(1);
        infl_pc <= mem_a;
      end
    end
  end

  fetch_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (jmp_valid),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .count    (count),
    .ent0     (ent0),
    .ent1     (ent1)
  );

endmodule

// File: tb/tb_avr_fetch.sv
// tb_avr_fetch: directed bench with ROM model and a
// scoreboard of expected instructions for avr_fetch.
module tb_avr_fetch;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce;
  logic [9:0]  mem_a;
  logic [15:0] mem_d;
  logic        jmp_valid;
  logic [9:0]  jmp_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [9:0]  ins_pc;
  logic [15:0] ins_word0;
  logic [15:0] ins_word1;
  logic        ins_len;

  logic [15:0] rom [1024];
  logic [15:0] rdata = 16'h0000;
  exp_t        sbq [$];
  int          errs = 0;
  int          checks = 0;
  logic [9:0]  nxt;

  always #5 clk = ~clk;

  // ROM: one-cycle latency, registered address/bank select
  always @(posedge clk) begin
    if (mem_ce) rdata <= rom[mem_a];
  end
  assign mem_d = rdata;

  avr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ce    (mem_ce),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .jmp_valid (jmp_valid),
    .jmp_pc    (jmp_pc),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_pc    (ins_pc),
    .ins_word0 (ins_word0),
    .ins_word1 (ins_word1),
    .ins_len   (ins_len)
  );

  function automatic logic tw(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) ||
           ((w & 16'hFE0C) == 16'h940C);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_seq(input logic [9:0] start,
                         input int n,
                         output logic [9:0] nx);
    logic [9:0] p;
    logic [9:0] p1;
    exp_t e;
    p = start;
    for (int i = 0; i < n; i++) begin
      p1    = p + 10'd1;
      e.pc  = p;
      e.w0  = rom[p];
      e.len = tw(rom[p]);
      e.w1  = e.len ? rom[p1] : 16'h0000;
      sbq.push_back(e);
      p = e.len ? p + 10'd2 : p + 10'd1;
    end
    nx = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    exp_t e;
    @(negedge clk);
    if (ins_valid && ins_ready) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errs++;
        $error("FAIL sb_extra got pc=%h exp=none", ins_pc);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_pc",  32'(ins_pc),    32'(e.pc));
        chk("sb_w0",  32'(ins_word0), 32'(e.w0));
        chk("sb_w1",  32'(ins_word1), 32'(e.w1));
        chk("sb_len", 32'(ins_len),   32'(e.len));
      end
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      samp();
      tick();
      k++;
    end
    chk(tag, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 16'hE000 | 16'(i);
    end
    rom[0]     = 16'hC004;
    rom[1]     = 16'hC03A;
    rom[2]     = 16'hC001;
    rom[3]     = 16'hC023;
    rom[5]     = 16'h940C;
    rom[6]     = 16'h0034;
    rom[10'h3FF] = 16'h9100;

    rst       = 1'b1;
    jmp_valid = 1'b0;
    jmp_pc    = '0;
    ins_ready = 1'b1;
    tick();
    tick();
    samp();
    chk("rst_ce",    32'(mem_ce),    32'd0);
    chk("rst_a",     32'(mem_a),     32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_pc",    32'(ins_pc),    32'd0);
    chk("rst_w0",    32'(ins_word0), 32'd0);
    chk("rst_w1",    32'(ins_word1), 32'd0);
    chk("rst_len",   32'(ins_len),   32'd0);
    tick();

    // reset release and sequential one/two-word fetch
    rst = 1'b0;
    exp_seq(10'd0, 12, nxt);
    samp();
    chk("c0_ce",    32'(mem_ce),    32'd1);
    chk("c0_a",     32'(mem_a),     32'd0);
    chk("c0_valid", 32'(ins_valid), 32'd0);
    tick();
    samp();
    chk("c1_valid", 32'(ins_valid), 32'd0);
    tick();
    samp();
    chk("c2_valid", 32'(ins_valid), 32'd1);
    tick();
    drain("seq_drain");

    // backpressure for 10 cycles
    ins_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      samp();
      if (i >= 1) begin
        chk("stall_valid", 32'(ins_valid), 32'd1);
        chk("stall_pc",    32'(ins_pc),    32'(nxt));
      end
      if (i >= 3) chk("stall_ce", 32'(mem_ce), 32'd0);
      tick();
    end
    exp_seq(nxt, 6, nxt);
    ins_ready = 1'b1;
    drain("stall_drain");

    // redirect while the buffer is full
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      samp();
      tick();
    end
    jmp_valid = 1'b1;
    jmp_pc    = 10'h123;
    samp();
    chk("jmp_a",  32'(mem_a),  32'h123);
    chk("jmp_ce", 32'(mem_ce), 32'd1);
    tick();
    jmp_valid = 1'b0;
    samp();
    chk("jmp1_valid", 32'(ins_valid), 32'd0);
    tick();
    samp();
    chk("jmp2_valid", 32'(ins_valid), 32'd1);
    chk("jmp2_pc",    32'(ins_pc),    32'h123);
    tick();
    exp_seq(10'h123, 4, nxt);
    ins_ready = 1'b1;
    drain("jmp_drain");

    // two-word instruction straddling the address wrap
    rom[0]    = 16'h0060;
    ins_ready = 1'b0;
    jmp_valid = 1'b1;
    jmp_pc    = 10'h3FF;
    samp();
    tick();
    jmp_valid = 1'b0;
    exp_seq(10'h3FF, 3, nxt);
    chk("wrap_next", 32'(nxt), 32'h003);
    ins_ready = 1'b1;
    drain("wrap_drain");

    // reset mid-fill with a read in flight
    ins_ready = 1'b0;
    jmp_valid = 1'b1;
    jmp_pc    = 10'h200;
    samp();
    tick();
    jmp_valid = 1'b0;
    samp();
    tick();
    samp();
    tick();
    rst       = 1'b1;
    ins_ready = 1'b1;
    samp();
    chk("mrst_valid", 32'(ins_valid), 32'd0);
    chk("mrst_ce",    32'(mem_ce),    32'd0);
    chk("mrst_a",     32'(mem_a),     32'd0);
    tick();
    rst = 1'b0;
    exp_seq(10'd0, 3, nxt);
    samp();
    chk("r0_ce",    32'(mem_ce),    32'd1);
    chk("r0_a",     32'(mem_a),     32'd0);
    chk("r0_valid", 32'(ins_valid), 32'd0);
    tick();
    samp();
    chk("r1_valid", 32'(ins_valid), 32'd0);
    tick();
    samp();
    chk("r2_valid", 32'(ins_valid), 32'd1);
    tick();
    drain("rst_drain");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
